// File: rtl/ct_f_spsram_ctrl_pkg.sv
// Shared definitions for the single-port SRAM request controller:
// controller states, response buffer depth and byte-lane geometry.
package ct_f_spsram_ctrl_pkg;

   typedef enum logic {
      ST_INIT = 1'b0,
      ST_RUN  = 1'b1
   } ctrl_state_t;

   localparam int FIFO_DEPTH     = 3;
   localparam int BYTE_BITS      = 8;
   localparam int BYTES_PER_WORD = 64 / BYTE_BITS;

   // Number of byte lanes in a word of the given width.
   function automatic int bytes_per_word(input int data_width);
      return data_width / BYTE_BITS;
   endfunction

endpackage

// File: rtl/ct_f_spsram_rsp_fifo.sv
// Three-entry synchronous response FIFO. Push and pop may happen in the
// same cycle; the upstream credit check guarantees it never overflows.
module ct_f_spsram_rsp_fifo
   import ct_f_spsram_ctrl_pkg::*;
#(
   parameter int WIDTH = 64
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head,
   output logic [1:0]       cnt,
   output logic             not_empty
);

   logic [WIDTH-1:0] mem [FIFO_DEPTH];
   logic [1:0]       wr_ptr;
   logic [1:0]       rd_ptr;
   logic             do_pop;

   function automatic logic [1:0] ptr_inc(input logic [1:0] p);
      return (p == 2'(FIFO_DEPTH - 1)) ? 2'd0 : p + 2'd1;
   endfunction

   assign not_empty = (cnt != 2'd0);
   assign do_pop    = pop & not_empty;
   assign head      = mem[rd_ptr];

   // Storage, pointers and occupancy count; reset empties the buffer.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= 2'd0;
         rd_ptr <= 2'd0;
         cnt    <= 2'd0;
         for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= push_data;
            wr_ptr      <= ptr_inc(wr_ptr);
         end
         if (do_pop) rd_ptr <= ptr_inc(rd_ptr);
         case ({push, do_pop})
            2'b10:   cnt <= cnt + 2'd1;
            2'b01:   cnt <= cnt - 2'd1;
            default: cnt <= cnt;
         endcase
      end
   end

endmodule

// File: rtl/ct_f_spsram_1024x64_ctrl.sv
// Request-side controller for the 1024x64 single-port SRAM wrapper.
// Optionally zero-fills the array after reset, then turns a valid/ready
// request stream into SRAM accesses and returns read data through a
// credit-protected 3-entry response buffer.
//
// Handshake: a request transfers in any cycle where req_vld & req_rdy;
// a response transfers in any cycle where rsp_vld & rsp_rdy. req_rdy
// depends only on internal state, never on req_vld/req_wr/rsp_rdy.
module ct_f_spsram_1024x64_ctrl
   import ct_f_spsram_ctrl_pkg::*;
#(
   parameter int ADDR_WIDTH = 10,
   parameter int DATA_WIDTH = 64,
   parameter bit INIT_EN    = 1'b1
) (
   input  logic                    CLK,
   input  logic                    RST,
   input  logic                    req_vld,
   output logic                    req_rdy,
   input  logic                    req_wr,
   input  logic [ADDR_WIDTH-1:0]   req_addr,
   input  logic [DATA_WIDTH-1:0]   req_wdata,
   input  logic [DATA_WIDTH/8-1:0] req_bmask,
   output logic                    rsp_vld,
   input  logic                    rsp_rdy,
   output logic [DATA_WIDTH-1:0]   rsp_rdata,
   output logic                    init_done,
   output logic [ADDR_WIDTH-1:0]   A,
   output logic                    CEN,
   output logic                    GWEN,
   output logic [DATA_WIDTH-1:0]   WEN,
   output logic [DATA_WIDTH-1:0]   D,
   input  logic [DATA_WIDTH-1:0]   Q
);

   localparam int NBYTES = bytes_per_word(DATA_WIDTH);

   ctrl_state_t           state;
   ctrl_state_t           state_next;
   logic [ADDR_WIDTH-1:0] init_cnt;
   logic                  init_last;
   logic                  init_done_q;
   logic                  rd_inflight;
   logic [1:0]            fifo_cnt;
   logic                  fifo_vld;
   logic [DATA_WIDTH-1:0] fifo_head;
   logic                  credit_ok;
   logic                  accept;

   // Terminal count of the zero-fill sweep: last address is being written.
   assign init_last = &init_cnt;

   // Buffered plus in-flight reads must leave room for one more response.
   assign credit_ok = ({1'b0, fifo_cnt} + {2'b00, rd_inflight}) < 3'(FIFO_DEPTH);
   assign init_done = init_done_q & ~RST;
   assign req_rdy   = init_done & credit_ok;
   assign accept    = req_vld & req_rdy;
   assign rsp_vld   = fifo_vld & ~RST;
   assign rsp_rdata = RST ? '0 : fifo_head;

   // Next-state logic: INIT ends after the last address is written.
   always_comb begin
      state_next = state;
      case (state)
         ST_INIT: if (init_last) state_next = ST_RUN;
         ST_RUN:  state_next = ST_RUN;
         default: state_next = ST_RUN;
      endcase
   end

   // State register, init sweep counter and read-in-flight marker.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state       <= INIT_EN ? ST_INIT : ST_RUN;
         init_cnt    <= '0;
         init_done_q <= 1'b0;
         rd_inflight <= 1'b0;
      end else begin
         state       <= state_next;
         init_done_q <= (state_next == ST_RUN);
         if (state == ST_INIT) init_cnt <= init_cnt + ADDR_WIDTH'(1);
         rd_inflight <= accept & ~req_wr;
      end
   end

   // SRAM pin drive: zero-fill during INIT, accepted request in RUN, idle otherwise.
   always_comb begin
      CEN  = 1'b1;
      GWEN = 1'b1;
      WEN  = '1;
      A    = '0;
      D    = '0;
      if (!RST) begin
         if (state == ST_INIT) begin
            CEN  = 1'b0;
            GWEN = 1'b0;
            WEN  = '0;
            A    = init_cnt;
         end else if (accept) begin
            CEN = 1'b0;
            A   = req_addr;
            if (req_wr) begin
               GWEN = 1'b0;
               D    = req_wdata;
               for (int b = 0; b < NBYTES; b++)
                  WEN[b*BYTE_BITS +: BYTE_BITS] = {BYTE_BITS{~req_bmask[b]}};
            end
         end
      end
   end

   ct_f_spsram_rsp_fifo #(
      .WIDTH (DATA_WIDTH)
   ) u_rsp_fifo (
      .clk       (CLK),
      .rst       (RST),
      .push      (rd_inflight),
      .push_data (Q),
      .pop       (rsp_vld & rsp_rdy),
      .head      (fifo_head),
      .cnt       (fifo_cnt),
      .not_empty (fifo_vld)
   );

endmodule

// File: tb/tb_ct_f_spsram_1024x64_ctrl.sv
// Directed bench for the SRAM request controller, with a behavioural
// 1024x64 SRAM attached to the controller's pins.
module tb_ct_f_spsram_1024x64_ctrl;

   logic        CLK;
   logic        RST;
   logic        req_vld;
   logic        req_rdy;
   logic        req_wr;
   logic [9:0]  req_addr;
   logic [63:0] req_wdata;
   logic [7:0]  req_bmask;
   logic        rsp_vld;
   logic        rsp_rdy;
   logic [63:0] rsp_rdata;
   logic        init_done;
   logic [9:0]  A;
   logic        CEN;
   logic        GWEN;
   logic [63:0] WEN;
   logic [63:0] D;
   logic [63:0] Q;

   int unsigned n_asserts;
   int unsigned n_fail;

   // clock / reset
   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   ct_f_spsram_1024x64_ctrl dut (
      .CLK       (CLK),
      .RST       (RST),
      .req_vld   (req_vld),
      .req_rdy   (req_rdy),
      .req_wr    (req_wr),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .req_bmask (req_bmask),
      .rsp_vld   (rsp_vld),
      .rsp_rdy   (rsp_rdy),
      .rsp_rdata (rsp_rdata),
      .init_done (init_done),
      .A         (A),
      .CEN       (CEN),
      .GWEN      (GWEN),
      .WEN       (WEN),
      .D         (D),
      .Q         (Q)
   );

   // behavioural single-port SRAM: bit-masked write, registered read
   logic [63:0] mem [1024];
   logic [63:0] q_r;
   assign Q = q_r;
   always @(posedge CLK) begin
      if (CEN === 1'b0) begin
         if (GWEN === 1'b0) mem[A] <= (mem[A] & WEN) | (D & ~WEN);
         else               q_r    <= mem[A];
      end
   end

   function automatic logic [63:0] pat(input int i);
      return {32'hC0DE_0000 + 32'(i), ~32'(i * 7)};
   endfunction

   task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
      n_asserts++;
      assert (obs === exp) else begin
         n_fail++;
         $error("%s FAIL: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic go();
      @(negedge CLK);
   endtask

   task automatic set_idle();
      req_vld   = 1'b0;
      req_wr    = 1'b0;
      req_addr  = '0;
      req_wdata = '0;
      req_bmask = '0;
   endtask

   task automatic set_wr(input logic [9:0] addr, input logic [63:0] data, input logic [7:0] mask);
      req_vld   = 1'b1;
      req_wr    = 1'b1;
      req_addr  = addr;
      req_wdata = data;
      req_bmask = mask;
   endtask

   task automatic set_rd(input logic [9:0] addr);
      req_vld   = 1'b1;
      req_wr    = 1'b0;
      req_addr  = addr;
      req_wdata = '0;
      req_bmask = '0;
   endtask

   // Entered just after RST drops at a negedge; checks n zero-fill cycles
   // and returns at the negedge of the following cycle.
   task automatic check_init(input int n);
      for (int i = 0; i < n; i++) begin
         #1;
         chk("init_cycle",
             {init_done, req_rdy, rsp_vld, CEN, GWEN, A, D, WEN},
             {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 10'(i), 64'd0, 64'd0});
         go();
      end
   endtask

   int accepted;

   initial begin
      n_asserts = 0;
      n_fail    = 0;
      RST       = 1'b1;
      rsp_rdy   = 1'b0;
      set_idle();

      // reset values
      repeat (2) go();
      #1;
      chk("rst_req_rdy", 160'(req_rdy), 160'(1'b0));
      chk("rst_rsp_vld", 160'(rsp_vld), 160'(1'b0));
      chk("rst_rsp_rdata", 160'(rsp_rdata), 160'(64'd0));
      chk("rst_init_done", 160'(init_done), 160'(1'b0));
      chk("rst_pins", {CEN, GWEN, WEN, A, D}, {1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 10'd0, 64'd0});

      // zero-fill sweep of all 1024 words
      go();
      RST = 1'b0;
      check_init(1024);
      #1;
      chk("init_done_rise", 160'(init_done), 160'(1'b1));
      chk("req_rdy_rise", 160'(req_rdy), 160'(1'b1));
      chk("idle_cen", 160'(CEN), 160'(1'b1));

      // read of the last address returns zero, latency 2
      go(); set_rd(10'h3FF); #1;
      chk("rd3ff_pins", {CEN, GWEN, A, WEN}, {1'b0, 1'b1, 10'h3FF, 64'hFFFF_FFFF_FFFF_FFFF});
      go(); set_idle(); #1;
      chk("rd3ff_lat1", 160'(rsp_vld), 160'(1'b0));
      go(); rsp_rdy = 1'b1; #1;
      chk("rd3ff_vld", 160'(rsp_vld), 160'(1'b1));
      chk("rd3ff_data", 160'(rsp_rdata), 160'(64'd0));
      go(); #1;
      chk("rd3ff_popped", 160'(rsp_vld), 160'(1'b0));

      // byte-masked write, then immediate read of the same address
      go(); set_wr(10'h005, 64'h1122_3344_5566_7788, 8'h0F); #1;
      chk("wr5_pins", {CEN, GWEN, A, D, WEN},
          {1'b0, 1'b0, 10'h005, 64'h1122_3344_5566_7788, 64'hFFFF_FFFF_0000_0000});
      go(); set_rd(10'h005); #1;
      chk("rd5_pins", {CEN, GWEN}, {1'b0, 1'b1});
      go(); set_idle(); #1;
      chk("rd5_lat1", 160'(rsp_vld), 160'(1'b0));
      go(); #1;
      chk("rd5_vld", 160'(rsp_vld), 160'(1'b1));
      chk("rd5_data", 160'(rsp_rdata), 160'(64'h0000_0000_5566_7788));

      // all-zero mask write still accesses the array but writes nothing
      go(); set_wr(10'h006, 64'hFFFF_FFFF_FFFF_FFFF, 8'h00); #1;
      chk("wr6_pins", {CEN, GWEN, WEN}, {1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF});
      go(); set_rd(10'h006);
      go(); set_idle();
      go(); #1;
      chk("rd6_vld", 160'(rsp_vld), 160'(1'b1));
      chk("rd6_data", 160'(rsp_rdata), 160'(64'd0));

      // backpressure: five reads with rsp_rdy low, only three accepted
      for (int k = 1; k <= 5; k++) begin
         go(); set_wr(10'(k), 64'h1111_1111_1111_1111 * 64'(k), 8'hFF);
      end
      accepted = 0;
      for (int i = 0; i < 5; i++) begin
         go(); rsp_rdy = 1'b0; set_rd(10'(i + 1)); #1;
         chk("bp_req_rdy", 160'(req_rdy), 160'(i < 3));
         if (req_rdy) accepted++;
      end
      go(); set_idle(); #1;
      chk("bp_accepted", 160'(accepted), 160'(3));
      chk("bp_full_rdy", 160'(req_rdy), 160'(1'b0));
      chk("bp_head", {rsp_vld, rsp_rdata}, {1'b1, 64'h1111_1111_1111_1111});
      go(); rsp_rdy = 1'b1; #1;
      chk("bp_drain1", {rsp_vld, rsp_rdata}, {1'b1, 64'h1111_1111_1111_1111});
      go(); #1;
      chk("bp_drain2", {rsp_vld, rsp_rdata}, {1'b1, 64'h2222_2222_2222_2222});
      chk("bp_rdy_back", 160'(req_rdy), 160'(1'b1));
      go(); #1;
      chk("bp_drain3", {rsp_vld, rsp_rdata}, {1'b1, 64'h3333_3333_3333_3333});
      go(); #1;
      chk("bp_empty", 160'(rsp_vld), 160'(1'b0));

      // full-throughput stream of 100 reads
      for (int j = 0; j < 100; j++) begin
         go(); set_wr(10'(256 + j), pat(j), 8'hFF);
      end
      for (int j = 0; j < 102; j++) begin
         go();
         if (j < 100) set_rd(10'(256 + j));
         else         set_idle();
         #1;
         if (j < 100) chk("st_req_rdy", 160'(req_rdy), 160'(1'b1));
         chk("st_rsp_vld", 160'(rsp_vld), 160'(j >= 2));
         if (j >= 2) chk("st_rsp_data", 160'(rsp_rdata), 160'(pat(j - 2)));
      end
      go(); #1;
      chk("st_done", 160'(rsp_vld), 160'(1'b0));

      // reset with two responses buffered and one read in flight
      rsp_rdy = 1'b0;
      for (int i = 0; i < 3; i++) begin
         go(); set_rd(10'(i + 1)); #1;
         chk("flush_acc", 160'(req_rdy), 160'(1'b1));
      end
      go(); set_idle(); RST = 1'b1; #1;
      chk("flush_rst_out", {rsp_vld, CEN, req_rdy, init_done, rsp_rdata},
          {1'b0, 1'b1, 1'b0, 1'b0, 64'd0});
      go(); RST = 1'b0;
      check_init(500);

      // reset again mid-sweep: counter restarts at zero
      RST = 1'b1; #1;
      chk("mid_rst_pins", {CEN, GWEN, A, D}, {1'b1, 1'b1, 10'd0, 64'd0});
      go(); RST = 1'b0;
      check_init(1024);
      set_rd(10'h005); #1;
      chk("reinit_done", {init_done, req_rdy, rsp_vld, CEN}, {1'b1, 1'b1, 1'b0, 1'b0});
      go(); set_idle(); #1;
      chk("reinit_lat1", 160'(rsp_vld), 160'(1'b0));
      go(); rsp_rdy = 1'b1; #1;
      chk("reinit_rd5", {rsp_vld, rsp_rdata}, {1'b1, 64'd0});
      go(); #1;
      chk("reinit_empty", 160'(rsp_vld), 160'(1'b0));

      $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
      $finish;
   end

endmodule

// File: doc/ct_f_spsram_1024x64_ctrl.md
# ct_f_spsram_1024x64_ctrl

Request-side controller for the single-port 1024x64 SRAM wrapper `ct_f_spsram_1024x64`; it sits directly upstream of the wrapper and drives its active-low control pins. It converts a valid/ready read/write request stream into SRAM accesses, with byte-masked writes. It returns read data through a credit-protected 3-entry response buffer, so `rsp_rdy` backpressure never loses SRAM output. After reset it optionally zero-fills the whole array before accepting traffic.

## Interface
- `ADDR_WIDTH`, 10, SRAM word address width (1024 words).
- `DATA_WIDTH`, 64, word width; must be a multiple of 8.
- `INIT_EN`, 1, 1 = zero-fill all 2^ADDR_WIDTH words after reset; 0 = skip.
- `CLK`  in  1  sole clock; all state updates on posedge.
- `RST`  in  1  synchronous reset, active-high.
- `req_vld`  in  1  request valid.
- `req_rdy`  out  1  request ready; transfer when `req_vld & req_rdy`.
- `req_wr`  in  1  1 = write, 0 = read.
- `req_addr`  in  ADDR_WIDTH  word address.
- `req_wdata`  in  DATA_WIDTH  write data.
- `req_bmask`  in  DATA_WIDTH/8  byte write enable, 1 = write that byte.
- `rsp_vld`  out  1  read data valid.
- `rsp_rdy`  in  1  consumer ready.
- `rsp_rdata`  out  DATA_WIDTH  read data, in request order.
- `init_done`  out  1  high once init has finished (or immediately after reset if `INIT_EN`=0).
- `A`  out  ADDR_WIDTH  SRAM address.
- `CEN`  out  1  SRAM chip enable, active-low.
- `GWEN`  out  1  SRAM global write enable, active-low.
- `WEN`  out  DATA_WIDTH  SRAM bit write enable, active-low.
- `D`  out  DATA_WIDTH  SRAM write data.
- `Q`  in  DATA_WIDTH  SRAM read data, valid the cycle after a read access.

## Operation
- FSM states: INIT and RUN.
  - `RST` forces INIT when `INIT_EN`=1, otherwise RUN.
  - INIT goes to RUN after the write to address 2^ADDR_WIDTH-1.
  - RUN is terminal until the next `RST`.
- INIT: each cycle `CEN`=0, `GWEN`=0, `WEN`=0, `D`=0, `A`=init counter (0 upward, +1 per cycle). Lasts exactly 2^ADDR_WIDTH cycles. `req_rdy`=0 throughout.
- Asserting `RST` during INIT restarts the counter at 0.
- RUN, `req_rdy` = `init_done & (fifo_cnt + rd_inflight < 3)`.
  - `req_rdy` does not depend on `req_vld`, `req_wr` or `rsp_rdy`: no combinational input-to-ready path.
- Accepted write: `CEN`=0, `GWEN`=0, `A`=`req_addr`, `D`=`req_wdata`, `WEN[8b+k]`=`~req_bmask[b]`. Produces no response.
- Accepted read: `CEN`=0, `GWEN`=1, `WEN`=all-ones, `A`=`req_addr`. Sets `rd_inflight` for the next cycle.
- An all-zero `req_bmask` on a write is still a legal access: `CEN`=0, no bits written.
- Idle (no transfer, RUN, or `RST` high): `CEN`=1, `GWEN`=1, `WEN`=all-ones, `A`=0, `D`=0.
- SRAM outputs are combinational from state/request. `RST` high overrides them to idle values.
- `rd_inflight` cycle: `Q` is pushed into the response FIFO at the end of that cycle.
  - The credit rule guarantees the FIFO never overflows.
  - Push and pop in the same cycle are both allowed.
- `rsp_vld` = FIFO non-empty; `rsp_rdata` = FIFO head; pop on `rsp_vld & rsp_rdy`.
- Reset values:
  - `req_rdy`=0, `rsp_vld`=0, `rsp_rdata`=0, `init_done`=0.
  - `CEN`=1, `GWEN`=1, `WEN`=all-ones, `A`=0, `D`=0.
  - fifo_cnt=0, rd_inflight=0.
- Reset flushes all buffered and in-flight responses.

## Timing
- Read accepted in cycle N: SRAM samples at the end of N; `Q` is valid in N+1 and pushed at the end of N+1; `rsp_vld` rises in N+2 (latency 2).
- Full throughput: one read per cycle is sustained while `rsp_rdy`=1.
  - With `rsp_rdy`=0, at most 3 reads are accepted; `req_rdy` stays low until a pop.
- Write-then-read to the same address in consecutive cycles returns the new data.
- `init_done` rises in the cycle after the last INIT write; `req_rdy` may rise in that same cycle.
  - With `INIT_EN`=1: `init_done` first high 2^ADDR_WIDTH cycles after `RST` deasserts.
  - With `INIT_EN`=0: `init_done` first high 1 cycle after `RST` deasserts.
- fifo_cnt is 2 bits and saturates at 3 by construction; the init counter is ADDR_WIDTH bits plus a terminal-count flag.

## Structure
- State encodings (INIT/RUN), FIFO depth (3) and bytes-per-word (`DATA_WIDTH/8`) are localparams in the shared controller package `ct_f_spsram_ctrl_pkg`.
- One sub-module: `ct_f_spsram_rsp_fifo`, a 3-entry synchronous FIFO with push/pop/count and a synchronous active-high reset.
- The top module holds the FSM, init counter, credit logic and SRAM pin drive. It instantiates alongside `ct_f_spsram_1024x64` at the next level up.

## Test plan
- Reset with `INIT_EN`=1: count cycles -> exactly 1024 writes with `D`=0 to addresses 0..1023; `init_done` and `req_rdy` rise in cycle 1024; a read of address 0x3FF returns 0.
- Write 0x1122334455667788 to 0x005 with `req_bmask`=0x0F, over prior zeros -> a read of 0x005 returns 0x0000000055667788 two cycles after acceptance.
- Hold `rsp_rdy`=0 and issue 5 back-to-back reads -> exactly 3 accepted, `req_rdy`=0 after the third. Release `rsp_rdy` -> data returned in order with no loss or duplication.
- Stream 100 reads with `rsp_rdy`=1 -> one accepted per cycle, 100 responses; the first `rsp_vld` is 2 cycles after the first acceptance.
- Assert `RST` at init cycle 500 -> the counter restarts at 0; a further 1024 write cycles occur before `init_done`.
- Assert `RST` with 2 responses buffered and 1 read in flight -> next cycle `rsp_vld`=0, `CEN`=1, and no stale response appears afterwards.
